// File: rtl/addr_decode_split.sv
// rtl/addr_decode_split.sv - registered address decode that splits line-crossing accesses
module addr_decode_split #(
  parameter int ADDR_W     = 64,
  parameter int LINE_BITS  = 6,
  parameter int CACHE_BITS = 14,
  parameter int WAYS       = 8,
  parameter int CNT_W      = 32,
  localparam int INDEX_W   = CACHE_BITS - $clog2(WAYS) - LINE_BITS,
  localparam int TAG_W     = ADDR_W - INDEX_W - LINE_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ADDR_W-1:0]    in_addr,
  input  logic [LINE_BITS-1:0] in_size,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [TAG_W-1:0]     out_tag,
  output logic [INDEX_W-1:0]   out_index,
  output logic [LINE_BITS-1:0] out_offset,
  output logic [LINE_BITS:0]   out_len,
  output logic                 out_first,
  output logic                 out_last,
  output logic [CNT_W-1:0]     access_count,
  output logic [CNT_W-1:0]     split_count
);

  if ((WAYS < 1) || ((WAYS & (WAYS - 1)) != 0) || (INDEX_W < 1)) begin : g_bad_geometry
    $error("addr_decode_split: WAYS must be a power of two and INDEX_W must be at least 1");
  end

  localparam int LINE_ADDR_W = ADDR_W - LINE_BITS;
  localparam logic [LINE_BITS:0]     LINE_BYTES = {1'b1, {LINE_BITS{1'b0}}};
  localparam logic [LINE_BITS:0]     LEN_ONE    = {{LINE_BITS{1'b0}}, 1'b1};
  localparam logic [LINE_ADDR_W-1:0] LINE_ONE   = {{(LINE_ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]       CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]       CNT_MAX    = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    SECOND = 2'd2
  } state_t;

  state_t                 state;
  logic [LINE_ADDR_W-1:0] pend_line;   // line address of piece B
  logic [LINE_BITS:0]     pend_len;    // length of piece B

  logic [LINE_BITS-1:0]   in_offset;
  logic [LINE_BITS:0]     end_pos;     // offset of the last byte, may run past the line
  logic                   in_split;
  logic [LINE_BITS:0]     total_len;
  logic [LINE_BITS:0]     len_a;
  logic [LINE_BITS:0]     len_b;
  logic [LINE_ADDR_W-1:0] next_line;
  logic                   accept;
  logic                   out_fire;

  assign in_offset = in_addr[LINE_BITS-1:0];
  assign end_pos   = {1'b0, in_offset} + {1'b0, in_size};
  assign in_split  = end_pos[LINE_BITS];
  assign total_len = {1'b0, in_size} + LEN_ONE;
  assign len_a     = LINE_BYTES - {1'b0, in_offset};
  // Bytes spilling into the next line: end position wrapped into that line, plus one.
  assign len_b     = {1'b0, end_pos[LINE_BITS-1:0]} + LEN_ONE;
  // Wraps modulo the line-address space so the all-ones line continues at line 0.
  assign next_line = in_addr[ADDR_W-1:LINE_BITS] + LINE_ONE;

  // Accept a new access when empty, or when the final piece of the current one leaves.
  assign in_ready = (state == IDLE) || (out_valid && out_ready && out_last);
  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Output register, piece-B holding register and state sequencing.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_tag    <= '0;
      out_index  <= '0;
      out_offset <= '0;
      out_len    <= '0;
      out_first  <= 1'b0;
      out_last   <= 1'b0;
      pend_line  <= '0;
      pend_len   <= '0;
    end else if (accept) begin
      state      <= HOLD;
      out_valid  <= 1'b1;
      out_tag    <= in_addr[ADDR_W-1:INDEX_W+LINE_BITS];
      out_index  <= in_addr[INDEX_W+LINE_BITS-1:LINE_BITS];
      out_offset <= in_offset;
      out_len    <= in_split ? len_a : total_len;
      out_first  <= 1'b1;
      out_last   <= !in_split;
      pend_line  <= next_line;
      pend_len   <= len_b;
    end else if (out_fire && (state == HOLD) && !out_last) begin
      state      <= SECOND;
      out_tag    <= pend_line[LINE_ADDR_W-1:INDEX_W];
      out_index  <= pend_line[INDEX_W-1:0];
      out_offset <= '0;
      out_len    <= pend_len;
      out_first  <= 1'b0;
      out_last   <= 1'b1;
    end else if (out_fire) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
    end
  end

  // Saturating statistics, bumped on the same edge an access is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      access_count <= '0;
      split_count  <= '0;
    end else if (accept) begin
      if (access_count != CNT_MAX) access_count <= access_count + CNT_ONE;
      if (in_split && (split_count != CNT_MAX)) split_count <= split_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_addr_decode_split.sv
// tb/tb_addr_decode_split.sv - randomized bench with a queue-based reference model
module tb_addr_decode_split;

  localparam int ADDR_W  = 64;
  localparam int LINE_B  = 6;
  localparam int INDEX_W = 5;
  localparam int TAG_W   = 53;
  localparam int CNT_W   = 32;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [ADDR_W-1:0]  in_addr = '0;
  logic [LINE_B-1:0]  in_size = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [TAG_W-1:0]   out_tag;
  logic [INDEX_W-1:0] out_index;
  logic [LINE_B-1:0]  out_offset;
  logic [LINE_B:0]    out_len;
  logic               out_first;
  logic               out_last;
  logic [CNT_W-1:0]   access_count;
  logic [CNT_W-1:0]   split_count;

  addr_decode_split dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_size(in_size),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_tag(out_tag), .out_index(out_index), .out_offset(out_offset), .out_len(out_len),
    .out_first(out_first), .out_last(out_last),
    .access_count(access_count), .split_count(split_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] tag;
    logic [63:0] idx;
    logic [63:0] off;
    logic [63:0] len;
    logic [63:0] first;
    logic [63:0] last;
  } piece_t;

  piece_t      q[$];
  logic [63:0] m_acc = 0;
  logic [63:0] m_split = 0;
  int          checks = 0;
  int          passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic piece_t mk(input logic [63:0] a, input logic [63:0] len,
                                input logic [63:0] f, input logic [63:0] l);
    piece_t p;
    p.tag = a >> 11;
    p.idx = (a >> 6) % 32;
    p.off = a % 64;
    p.len = len;
    p.first = f;
    p.last = l;
    return p;
  endfunction

  // Reference: break the access into line pieces by plain byte arithmetic.
  task automatic model_accept(input logic [63:0] a, input logic [63:0] size);
    logic [63:0] off, tot, len_a, a2;
    off = a % 64;
    tot = size + 1;
    if (m_acc != 64'hFFFF_FFFF) m_acc++;
    if (off + tot > 64) begin
      len_a = 64 - off;
      a2 = ((a >> 6) + 64'd1) << 6;
      q.push_back(mk(a, len_a, 1, 0));
      q.push_back(mk(a2, tot - len_a, 0, 1));
      if (m_split != 64'hFFFF_FFFF) m_split++;
    end else begin
      q.push_back(mk(a, tot, 1, 1));
    end
  endtask

  function automatic bit exp_ready(input logic r);
    return (q.size() == 0) || (r && (q[0].last == 1));
  endfunction

  task automatic compare_all();
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("in_ready", 64'(in_ready), 64'(exp_ready(out_ready)));
    chk("access_count", 64'(access_count), m_acc);
    chk("split_count", 64'(split_count), m_split);
    if (q.size() != 0) begin
      chk("out_tag", 64'(out_tag), q[0].tag);
      chk("out_index", 64'(out_index), q[0].idx);
      chk("out_offset", 64'(out_offset), q[0].off);
      chk("out_len", 64'(out_len), q[0].len);
      chk("out_first", 64'(out_first), q[0].first);
      chk("out_last", 64'(out_last), q[0].last);
    end
  endtask

  // One clock: drive at the falling edge, check, then advance the model on the rising edge.
  task automatic cycle(input logic v, input logic [63:0] a, input logic [5:0] s,
                       input logic r, input logic rs);
    bit acc, fire;
    @(negedge clk);
    in_valid = v; in_addr = a; in_size = s; out_ready = r; reset = rs;
    #1;
    compare_all();
    acc  = !rs && v && exp_ready(r);
    fire = !rs && (q.size() != 0) && r;
    @(posedge clk);
    if (rs) begin
      q.delete();
      m_acc = 0;
      m_split = 0;
    end else begin
      if (fire) void'(q.pop_front());
      if (acc) model_accept(a, 64'(s));
    end
    #1;
  endtask

  logic [63:0] ra;

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 64'(out_valid), 0);
    chk("reset in_ready", 64'(in_ready), 1);
    chk("reset access_count", 64'(access_count), 0);
    chk("reset out_len", 64'(out_len), 0);

    // Unsplit access.
    cycle(1, 64'h1234, 6'd3, 0, 0);
    chk("unsplit tag", 64'(out_tag), 64'h2);
    chk("unsplit index", 64'(out_index), 8);
    chk("unsplit offset", 64'(out_offset), 64'h34);
    chk("unsplit len", 64'(out_len), 4);
    chk("unsplit first/last", 64'({out_first, out_last}), 3);
    chk("unsplit access_count", 64'(access_count), 1);
    chk("unsplit split_count", 64'(split_count), 0);

    // Split access, accepted as the unsplit piece leaves.
    cycle(1, 64'h107C, 6'd7, 1, 0);
    chk("split A offset", 64'(out_offset), 64'h3C);
    chk("split A index", 64'(out_index), 1);
    chk("split A len", 64'(out_len), 4);
    chk("split A first/last", 64'({out_first, out_last}), 2);
    chk("split_count", 64'(split_count), 1);

    // Backpressure on piece A.
    for (int i = 0; i < 3; i++) begin
      cycle(1, 64'h40, 6'd0, 0, 0);
      chk("bp in_ready", 64'(in_ready), 0);
      chk("bp access_count", 64'(access_count), 2);
      chk("bp offset", 64'(out_offset), 64'h3C);
    end
    cycle(0, 64'h0, 6'd0, 1, 0);
    chk("split B tag", 64'(out_tag), 2);
    chk("split B index", 64'(out_index), 2);
    chk("split B offset", 64'(out_offset), 0);
    chk("split B len", 64'(out_len), 4);
    chk("split B first/last", 64'({out_first, out_last}), 1);
    cycle(0, 64'h0, 6'd0, 1, 0);
    chk("drained", 64'(out_valid), 0);

    // Wrap from the all-ones line to line 0.
    cycle(1, 64'hFFFF_FFFF_FFFF_FFF0, 6'd31, 1, 0);
    chk("wrap A offset", 64'(out_offset), 64'h30);
    chk("wrap A len", 64'(out_len), 16);
    cycle(0, 64'h0, 6'd0, 1, 0);
    chk("wrap B tag", 64'(out_tag), 0);
    chk("wrap B index", 64'(out_index), 0);
    chk("wrap B len", 64'(out_len), 16);
    cycle(0, 64'h0, 6'd0, 1, 0);

    // Streaming unsplit accesses.
    for (int i = 0; i < 4; i++) begin
      cycle(1, 64'h100 + 64'(i * 64 + i), 6'd3, 1, 0);
      chk("stream valid", 64'(out_valid), 1);
      chk("stream offset", 64'(out_offset), 64'(i));
      chk("stream access_count", 64'(access_count), 64'(4 + i));
    end
    cycle(0, 64'h0, 6'd0, 1, 0);

    // Reset while piece B is held.
    cycle(1, 64'h107C, 6'd7, 1, 0);
    cycle(0, 64'h0, 6'd0, 1, 0);
    cycle(0, 64'h0, 6'd0, 0, 0);
    chk("pre-reset B held", 64'({out_valid, out_first, out_last}), 5);
    cycle(0, 64'h0, 6'd0, 0, 1);
    chk("mid reset out_valid", 64'(out_valid), 0);
    chk("mid reset counts", 64'({access_count, split_count}), 0);
    chk("mid reset in_ready", 64'(in_ready), 1);
    cycle(0, 64'h0, 6'd0, 1, 0);
    chk("no late B", 64'(out_valid), 0);

    // Reset beats a simultaneous handshake.
    cycle(1, 64'h1234, 6'd3, 1, 1);
    chk("reset+hs access_count", 64'(access_count), 0);
    chk("reset+hs out_valid", 64'(out_valid), 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      ra = {$urandom, $urandom};
      if ($urandom_range(0, 2) == 0) ra[5:0] = 6'($urandom_range(40, 63));
      if ($urandom_range(0, 40) == 0) ra[63:6] = '1;
      cycle(1'($urandom_range(0, 9) < 7), ra, 6'($urandom_range(0, 63)),
            1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 199) == 0));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
